// File: rtl/hspi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hspi_pkg
// Brief    : Shared types and constants for the HSPI transmit path
//            (burst state encoding, header framing bytes).
// Revision : 1.0 - initial release
// ============================================================================
package hspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_PAD  = 3'd3,
        ST_END  = 3'd4
    } hspi_state_t;

    localparam logic [7:0]  HSPI_SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  HSPI_PAD_BYTE  = 8'h00;
    localparam int unsigned HSPI_HDR_LEN   = 4;

endpackage
`default_nettype wire

// File: rtl/hspi_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : hspi_tx_scheduler_if
// Brief    : Capture-FIFO read port plus hspi_master application interface
//            as seen by the transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface hspi_tx_scheduler_if #(
    parameter int unsigned LVL_W = 12
);
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic             fifo_rd;
    logic             req;
    logic [15:0]      xfer_len;
    logic             usdf;
    logic             ack;
    logic [7:0]       payload_data;

    // Scheduler side: reads the FIFO, drives the master request.
    modport master (
        input  fifo_level, fifo_empty, fifo_dout, ack,
        output fifo_rd, req, xfer_len, usdf, payload_data
    );

    // Environment side: FIFO and hspi_master.
    modport slave (
        output fifo_level, fifo_empty, fifo_dout, ack,
        input  fifo_rd, req, xfer_len, usdf, payload_data
    );
endinterface
`default_nettype wire

// File: rtl/hspi_flush_timer.sv
`default_nettype none
// ============================================================================
// Module   : hspi_flush_timer
// Brief    : Idle counter that flags when a partial burst has waited
//            TIMEOUT_CYC cycles. Only built with HSPI_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef HSPI_SCHED_TIMEOUT_EN
module hspi_flush_timer #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic hit
);
    localparam int unsigned   c_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_W-1:0] c_HIT = c_W'(TIMEOUT_CYC - 1);

    logic [c_W-1:0] r_cnt;

    // Count while the owner holds count_en, otherwise restart from zero.
    always_ff @(posedge clk) begin
        if (rst || !count_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign hit = (r_cnt == c_HIT);
endmodule
`endif
`default_nettype wire

// File: rtl/hspi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hspi_tx_scheduler
// Brief    : Frames capture-FIFO bytes into fixed-length HSPI bursts
//            (4-byte header, payload, zero padding) for hspi_master.
//            Optional partial-burst flush: HSPI_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hspi_tx_scheduler
    import hspi_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 512,
    parameter int unsigned LVL_W       = 12,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    hspi_tx_scheduler_if.master bus,
    output logic                busy,
    output logic [7:0]          seq
);
    localparam logic [15:0]  c_BURST_LEN = 16'(BURST_LEN);
    localparam int unsigned  c_PAY_MAX   = BURST_LEN - HSPI_HDR_LEN;
    localparam logic [15:0]  c_PAY_MAX16 = 16'(c_PAY_MAX);

    hspi_state_t r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;      // bytes of the current burst already acked
    logic [15:0] r_len, w_len_nxt;      // payload bytes taken from the FIFO
    logic        r_usdf, w_usdf_nxt;
    logic [7:0]  r_seq, w_seq_nxt;

    logic [LVL_W-1:0] w_level;
    logic [31:0]      w_level_u;
    logic             w_full;
    logic             w_timeout_hit;
    logic             w_start;

    assign w_level   = bus.fifo_level;
    assign w_level_u = 32'(w_level);
    assign w_full    = (w_level_u >= c_PAY_MAX);
    assign w_start   = enable && (w_full || w_timeout_hit);

`ifdef HSPI_SCHED_TIMEOUT_EN
    logic w_partial;
    logic w_timer_en;

    // The timer only runs while a partial burst is waiting; a start (which
    // coincides with hit) drops the enable so the count restarts at zero.
    assign w_partial  = (w_level_u != 32'd0) && !w_full;
    assign w_timer_en = (r_state == ST_IDLE) && enable && w_partial && !w_timeout_hit;

    hspi_flush_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (w_timer_en),
        .hit      (w_timeout_hit)
    );
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_usdf  <= 1'b0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_usdf  <= w_usdf_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    // Next-state logic plus the byte/handshake outputs toward the master.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_usdf_nxt       = r_usdf;
        w_seq_nxt        = r_seq;
        bus.req          = 1'b0;
        bus.fifo_rd      = 1'b0;
        bus.payload_data = HSPI_SYNC_BYTE;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_HDR;
                    w_cnt_nxt   = '0;
                    w_len_nxt   = w_full ? c_PAY_MAX16 : 16'(w_level_u);
                    w_usdf_nxt  = !w_full;
                end
            end
            ST_HDR: begin
                bus.req = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    bus.payload_data = HSPI_SYNC_BYTE;
                    2'd1:    bus.payload_data = r_seq;
                    2'd2:    bus.payload_data = r_len[7:0];
                    default: bus.payload_data = r_len[15:8];
                endcase
                if (bus.ack) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt[1:0] == 2'd3) begin
                        w_state_nxt = (r_len != 16'd0) ? ST_PAY : ST_PAD;
                    end
                end
            end
            ST_PAY: begin
                bus.req          = 1'b1;
                bus.payload_data = bus.fifo_dout;
                // len came from fifo_level, so the empty gate is only a guard.
                bus.fifo_rd      = bus.ack && !bus.fifo_empty;
                if (bus.ack) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == r_len + 16'd3) begin
                        w_state_nxt = (r_cnt + 16'd1 < c_BURST_LEN) ? ST_PAD : ST_END;
                    end
                end
            end
            ST_PAD: begin
                bus.req          = 1'b1;
                bus.payload_data = HSPI_PAD_BYTE;
                if (bus.ack) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt + 16'd1 == c_BURST_LEN) begin
                        w_state_nxt = ST_END;
                    end
                end
            end
            ST_END: begin
                w_seq_nxt   = r_seq + 8'd1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.xfer_len = c_BURST_LEN;
    assign bus.usdf     = r_usdf;
    assign busy         = (r_state != ST_IDLE);
    assign seq          = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_hspi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hspi_tx_scheduler
// Brief    : Directed self-checking bench for hspi_tx_scheduler with a
//            16-byte burst (12 payload bytes) and an 8-cycle flush timeout.
//            Timeout flush steps run when HSPI_SCHED_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hspi_tx_scheduler;

    localparam int unsigned BL  = 16;
    localparam int unsigned PM  = 12;
    localparam int unsigned TOC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       busy;
    logic [7:0] seq;

    hspi_tx_scheduler_if #(.LVL_W(12)) bus ();

    hspi_tx_scheduler #(
        .BURST_LEN   (BL),
        .LVL_W       (12),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .busy   (busy),
        .seq    (seq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q[$];
    logic [7:0] got[$];
    logic [7:0] exp_d[$];
    int         exp_seq;

    logic       s_req, s_rd, s_usdf, s_busy;
    logic [7:0] s_pd, s_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // One clock: drive inputs, sample outputs at negedge, then pop the model FIFO.
    task automatic cycle(input logic a);
        bus.ack        = a;
        bus.fifo_level = 12'(q.size());
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_dout  = (q.size() > 0) ? q[0] : 8'h00;
        @(negedge clk);
        s_req  = bus.req;
        s_rd   = bus.fifo_rd;
        s_usdf = bus.usdf;
        s_pd   = bus.payload_data;
        s_busy = busy;
        s_seq  = seq;
        @(posedge clk);
        #1;
        if (s_rd && q.size() > 0) void'(q.pop_front());
    endtask

    task automatic snap(input int n);
        exp_d.delete();
        for (int i = 0; i < n; i++) exp_d.push_back(q[i]);
    endtask

    // Run until req falls, collecting acked bytes; optional ack gaps / enable drop.
    task automatic do_burst(input bit gap, input int drop_at,
                            output int ncyc, output int npops, output int nbad, output bit saw_usdf);
        bit   seen  = 1'b0;
        bit   done  = 1'b0;
        bit   phase = 1'b1;
        logic a;
        int   guard = 0;
        got.delete();
        ncyc = 0; npops = 0; nbad = 0; saw_usdf = 1'b0;
        while (!done && guard < 200) begin
            a = (gap && seen) ? phase : 1'b1;
            cycle(a);
            guard++;
            if (s_req) begin
                seen = 1'b1;
                ncyc++;
                saw_usdf |= s_usdf;
                if (a) begin
                    got.push_back(s_pd);
                    if (got.size() == drop_at) enable = 1'b0;
                end
                phase = ~phase;
            end else if (seen) begin
                done = 1'b1;
            end
            if (s_rd) begin
                npops++;
                if (!a) nbad++;
            end
        end
        chk("burst_done", 32'(done), 32'd1);
    endtask

    task automatic check_burst(input string tag, input logic [7:0] sq, input int n);
        logic [7:0]  e;
        logic [31:0] o;
        chk({tag, "_nbytes"}, got.size(), BL);
        for (int i = 0; i < int'(BL); i++) begin
            if (i == 0)          e = 8'hA5;
            else if (i == 1)     e = sq;
            else if (i == 2)     e = 8'(n);
            else if (i == 3)     e = 8'h00;
            else if (i - 4 < n)  e = exp_d[i-4];
            else                 e = 8'h00;
            o = (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
            chk($sformatf("%s_b%0d", tag, i), o, 32'(e));
        end
    endtask

    initial begin
        int  ncyc, npops, nbad, cnt;
        bit  su;

        rst = 1'b1; enable = 1'b0;
        bus.ack = 1'b0; bus.fifo_level = '0; bus.fifo_empty = 1'b1; bus.fifo_dout = 8'h00;

        // Reset values
        cycle(1'b0);
        cycle(1'b0);
        chk("rst_req",  32'(s_req),  32'd0);
        chk("rst_rd",   32'(s_rd),   32'd0);
        chk("rst_usdf", 32'(s_usdf), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_seq",  32'(s_seq),  32'd0);
        chk("rst_pd",   32'(s_pd),   32'hA5);
        chk("rst_xlen", 32'(bus.xfer_len), BL);
        rst = 1'b0;
        exp_seq = 0;

        // Empty FIFO with enable and stray acks: nothing happens
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (s_req || s_busy || s_rd) cnt++;
        end
        chk("empty_idle", cnt, 0);
        chk("empty_seq", 32'(s_seq), 32'd0);

`ifndef HSPI_SCHED_TIMEOUT_EN
        // Short data never starts a burst without the flush timer
        for (int i = 0; i < 5; i++) q.push_back(8'h60 + 8'(i));
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            if (s_req || s_rd || s_busy) cnt++;
        end
        chk("short_no_req", cnt, 0);
`else
        // Partial flush: 5 bytes, req after TIMEOUT_CYC idle cycles
        for (int i = 0; i < 5; i++) q.push_back(8'h60 + 8'(i));
        snap(5);
        cnt = -1;
        for (int i = 0; i < 20 && cnt < 0; i++) begin
            cycle(1'b0);
            if (s_req) cnt = i;
        end
        chk("to_latency", cnt, 8);
        do_burst(1'b0, -1, ncyc, npops, nbad, su);
        check_burst("to", 8'(exp_seq), 5);
        chk("to_pops", npops, 5);
        chk("to_usdf", 32'(su), 32'd1);
        exp_seq++;
`endif
        enable = 1'b0; q.delete();
        cycle(1'b0);

        // Full burst, ack every cycle
        for (int i = 0; i < 20; i++) q.push_back(8'h10 + 8'(i));
        snap(PM);
        enable = 1'b1;
        do_burst(1'b0, -1, ncyc, npops, nbad, su);
        check_burst("full", 8'(exp_seq), PM);
        chk("full_cyc",  ncyc, BL);
        chk("full_pops", npops, PM);
        chk("full_usdf", 32'(su), 32'd0);
        exp_seq++;
        enable = 1'b0; q.delete();
        cycle(1'b0);
        chk("full_seq",  32'(s_seq), 32'(exp_seq));
        chk("full_busy", 32'(s_busy), 32'd0);

        // Ack toggling: same bytes, pops only on ack, 2*BL-1 cycles
        for (int i = 0; i < 12; i++) q.push_back(8'h40 + 8'(i));
        snap(PM);
        enable = 1'b1;
        do_burst(1'b1, -1, ncyc, npops, nbad, su);
        check_burst("gap", 8'(exp_seq), PM);
        chk("gap_cyc",   ncyc, 2 * BL - 1);
        chk("gap_pops",  npops, PM);
        chk("gap_badrd", nbad, 0);
        exp_seq++;
        enable = 1'b0; q.delete();
        cycle(1'b0);

        // Enable dropped mid-burst: burst completes, no new burst
        for (int i = 0; i < 30; i++) q.push_back(8'h80 + 8'(i));
        snap(PM);
        enable = 1'b1;
        do_burst(1'b0, 6, ncyc, npops, nbad, su);
        check_burst("drop", 8'(exp_seq), PM);
        chk("drop_pops", npops, PM);
        exp_seq++;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (s_req || s_rd || s_busy) cnt++;
        end
        chk("drop_idle",  cnt, 0);
        chk("drop_qsize", q.size(), 18);
        snap(PM);
        enable = 1'b1;
        do_burst(1'b0, -1, ncyc, npops, nbad, su);
        enable = 1'b0;
        check_burst("resume", 8'(exp_seq), PM);
        exp_seq++;
        q.delete();
        cycle(1'b0);

        // Reset during payload
        for (int i = 0; i < 20; i++) q.push_back(8'hC0 + 8'(i));
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30 && cnt < 6; i++) begin
            cycle(1'b1);
            if (s_req) cnt++;
        end
        chk("rstm_reach", cnt, 6);
        rst = 1'b1; enable = 1'b0;
        cycle(1'b1);
        rst = 1'b0;
        cycle(1'b1);
        chk("rstm_req",  32'(s_req),  32'd0);
        chk("rstm_rd",   32'(s_rd),   32'd0);
        chk("rstm_seq",  32'(s_seq),  32'd0);
        chk("rstm_busy", 32'(s_busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1);
            if (s_rd) cnt++;
        end
        chk("rstm_norid", cnt, 0);
        chk("rstm_qsize", q.size(), 17);
        exp_seq = 0;
        snap(PM);
        enable = 1'b1;
        do_burst(1'b0, -1, ncyc, npops, nbad, su);
        enable = 1'b0;
        check_burst("postrst", 8'(exp_seq), PM);
        exp_seq++;
        q.delete();
        cycle(1'b0);

        // Sequence wrap over 257 consecutive bursts
        enable = 1'b1;
        for (int b = 0; b < 257; b++) begin
            for (int i = 0; i < 12; i++) q.push_back(8'(b + i));
            do_burst(1'b0, -1, ncyc, npops, nbad, su);
            chk($sformatf("wrap_seq%0d", b), (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF,
                32'(exp_seq & 255));
            exp_seq = (exp_seq + 1) & 255;
        end
        enable = 1'b0;
        cycle(1'b0);
        chk("wrap_final_seq", 32'(s_seq), 32'(exp_seq));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
